dcache_refill_unit: RTL

Miss-repair engine directly downstream of the dCache controller. It accepts a read-miss repair request and missed address, and fetches the 1024-bit line from memory as a single burst of 32-bit beats. It then assembles the line, drives it back into the controller's arbiter write port, and pulses repair_resolved. It sits between the controller's arbiter-facing miss outputs and the memory bus.

---
 rtl/dcache_refill_unit_if.sv | 42 ++++
 rtl/dcache_refill_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dcache_refill_unit_if.sv
//------------------------------------------------------------------------------
// Module   : dcache_refill_unit_if
// Brief    : Controller-side and memory-side bus bundle of the dCache refill unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dcache_refill_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 1024,
  parameter int BEAT_BITS  = 32
);
  logic                    read_repair_request;
  logic [ADDR_WIDTH-1:0]   missed_addr;
  logic                    waddr_valid;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [LINE_BITS-1:0]    wdata;
  logic [LINE_BITS/8-1:0]  wmask;
  logic                    repair_resolved;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic                    mem_resp_valid;
  logic [BEAT_BITS-1:0]    mem_resp_data;
  logic                    busy;
  logic                    refill_error;

  // master: the refill unit; slave: controller plus memory
  modport master (
    input  read_repair_request, missed_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    output waddr_valid, waddr, wdata, wmask, repair_resolved,
           mem_req_valid, mem_req_addr, busy, refill_error
  );

  modport slave (
    output read_repair_request, missed_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  waddr_valid, waddr, wdata, wmask, repair_resolved,
           mem_req_valid, mem_req_addr, busy, refill_error
  );
endinterface

`default_nettype wire

// File: rtl/dcache_refill_unit.sv
//------------------------------------------------------------------------------
// Module   : dcache_refill_unit
// Brief    : Fetches a missed cache line as one memory burst, assembles it and
//            writes it back to the controller. Optional watchdog: DCACHE_REFILL_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dcache_refill_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_BITS      = 1024,
  parameter int BEAT_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  dcache_refill_unit_if.master bus
);

  localparam int c_BEATS      = LINE_BITS / BEAT_BITS;
  localparam int c_BEAT_CNT_W = $clog2(c_BEATS);
  localparam int c_OFFSET_W   = $clog2(LINE_BITS / 8);

  if ((LINE_BITS % BEAT_BITS) != 0 || c_BEATS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("dcache_refill_unit: unsupported LINE_BITS/BEAT_BITS/TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RECV    = 3'd2,
    S_WRITE   = 3'd3,
    S_RESOLVE = 3'd4,
    S_COOL    = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [c_BEAT_CNT_W-1:0]  r_beat;
  logic [LINE_BITS-1:0]     r_line;
  logic                     w_beat;
  logic                     w_last;
  logic                     w_timeout;
  logic                     w_mem_req_valid;
  logic                     w_waddr_valid;
  logic                     w_resolved;

  assign w_beat = (r_state == S_RECV) && bus.mem_resp_valid;
  assign w_last = (r_beat == c_BEAT_CNT_W'(c_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_mem_req_valid = 1'b0;
    w_waddr_valid   = 1'b0;
    w_resolved      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.read_repair_request) w_next = S_REQ;
      end
      S_REQ: begin
        w_mem_req_valid = 1'b1;
        if (w_timeout)              w_next = S_COOL;
        else if (bus.mem_req_ready) w_next = S_RECV;
      end
      S_RECV: begin
        if (w_timeout)            w_next = S_COOL;
        else if (w_beat && w_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_waddr_valid = 1'b1;
        w_next        = S_RESOLVE;
      end
      S_RESOLVE: begin
        w_resolved = 1'b1;
        w_next     = S_COOL;
      end
      // COOL swallows the controller's late request deassert
      S_COOL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_beat <= '0;
      r_line <= '0;
    end else begin
      if (r_state == S_IDLE && bus.read_repair_request) begin
        r_addr <= bus.missed_addr;
        r_beat <= '0;
      end
      if (w_beat) begin
        r_line[r_beat*BEAT_BITS +: BEAT_BITS] <= bus.mem_resp_data;
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
    end
  end

`ifdef DCACHE_REFILL_TIMEOUT_EN
  localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_WDOG_W-1:0] r_wdog;
  logic                r_err;

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without progress.
  assign w_timeout = ((r_state == S_REQ) || (r_state == S_RECV && !bus.mem_resp_valid)) &&
                     (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_beat) begin
        r_wdog <= '0;
      end else if (r_state == S_REQ || r_state == S_RECV) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign bus.refill_error = r_err;
`else
  assign w_timeout        = 1'b0;
  assign bus.refill_error = 1'b0;
`endif

  assign bus.mem_req_valid   = w_mem_req_valid;
  assign bus.mem_req_addr    = {r_addr[ADDR_WIDTH-1:c_OFFSET_W], {c_OFFSET_W{1'b0}}};
  assign bus.waddr_valid     = w_waddr_valid;
  assign bus.waddr           = r_addr;
  assign bus.wdata           = r_line;
  assign bus.wmask           = {(LINE_BITS/8){w_waddr_valid}};
  assign bus.repair_resolved = w_resolved;
  assign bus.busy            = (r_state != S_IDLE);

endmodule

`default_nettype wire
